// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan observer: hex pattern table,
// blank pattern and capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_e;

    // Active-low gfedcba pattern that the display drivers emit for a nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0011000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex pattern table: recovers the nibble and
// flags whether the pattern is a legal digit or the all-off blank.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    // Table patterns are unique, so at most one entry matches.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        blank  = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            legal  = legal | (seg == hex_to_seg(4'(i)));
            nibble = (seg == hex_to_seg(4'(i))) ? 4'(i) : nibble;
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Observes a scan-multiplexed seven-segment bus, waits for each digit to be
// stable, decodes it and stores one nibble per digit position.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [6:0]              SEG,
    input  logic [NUM_DIGITS-1:0]   DIG_EN,
    input  logic                    CLR,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
    output logic                    UPDATE,
    output logic                    ERR
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

    logic [6:0]              seg_s1_r, seg_s2_r;
    logic [NUM_DIGITS-1:0]   en_s1_r, en_s2_r;
    scan_state_e             state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [4*NUM_DIGITS-1:0] value_r, value_s;
    logic [NUM_DIGITS-1:0]   valid_r, valid_s;
    logic                    update_r, update_s;
    logic                    err_r, err_s;
    logic                    commit_s;
    logic                    blanking_s, bad_sel_s, candidate_s, same_s;
    logic [IDX_W-1:0]        idx_s;
    logic [3:0]              nibble_s;
    logic                    legal_s, blank_s;

    seg7_to_hex u_decode (
        .seg    (seg_s1_r),
        .nibble (nibble_s),
        .legal  (legal_s),
        .blank  (blank_s)
    );

    // Classify the newest sample and encode the selected digit index.
    always_comb begin
        blanking_s  = (en_s1_r == '0);
        bad_sel_s   = |(en_s1_r & (en_s1_r - NUM_DIGITS'(1)));
        candidate_s = !blanking_s && !bad_sel_s;
        same_s      = (seg_s1_r == seg_s2_r) && (en_s1_r == en_s2_r);
        idx_s       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            idx_s = idx_s | (en_s1_r[i] ? IDX_W'(i) : '0);
        end
    end

    // Stability FSM: commit once when a candidate pair has been seen
    // STABLE_CYCLES times in a row; the counter saturates at STABLE_CYCLES.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        if (!candidate_s) begin
            state_s = IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = SETTLE;
                    cnt_s   = CNT_ONE;
                end
                SETTLE: begin
                    if (!same_s) begin
                        cnt_s = CNT_ONE;
                    end else if (cnt_r >= CNT_LAST) begin
                        commit_s = 1'b1;
                        state_s  = HOLD;
                        cnt_s    = CNT_FULL;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!same_s) begin
                        state_s = SETTLE;
                        cnt_s   = CNT_ONE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Commit decode into per-digit storage; illegal patterns only raise ERR.
    always_comb begin
        value_s  = value_r;
        valid_s  = valid_r;
        update_s = 1'b0;
        err_s    = err_r | bad_sel_s;
        if (commit_s) begin
            if (legal_s) begin
                value_s[{idx_s, 2'b00} +: 4] = nibble_s;
                valid_s[idx_s]               = 1'b1;
                update_s = (value_r[{idx_s, 2'b00} +: 4] != nibble_s) || !valid_r[idx_s];
            end else if (blank_s) begin
                valid_s[idx_s] = 1'b0;
                update_s       = valid_r[idx_s];
            end else begin
                err_s = 1'b1;
            end
        end else begin
            update_s = 1'b0;
        end
    end

    // Input sampling, state and storage registers; CLR keeps the input stage.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            seg_s1_r <= 7'd0;
            seg_s2_r <= 7'd0;
            en_s1_r  <= '0;
            en_s2_r  <= '0;
            state_r  <= IDLE;
            cnt_r    <= '0;
            value_r  <= '0;
            valid_r  <= '0;
            update_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            seg_s1_r <= SEG;
            seg_s2_r <= seg_s1_r;
            en_s1_r  <= DIG_EN;
            en_s2_r  <= en_s1_r;
            if (CLR) begin
                state_r  <= IDLE;
                cnt_r    <= '0;
                value_r  <= '0;
                valid_r  <= '0;
                update_r <= 1'b0;
                err_r    <= 1'b0;
            end else begin
                state_r  <= state_s;
                cnt_r    <= cnt_s;
                value_r  <= value_s;
                valid_r  <= valid_s;
                update_r <= update_s;
                err_r    <= err_s;
            end
        end
    end

    assign VALUE       = value_r;
    assign DIGIT_VALID = valid_r;
    assign UPDATE      = update_r;
    assign ERR         = err_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (4 digits, 4 stable cycles) with
// hand-computed expectations for each scenario.
module tb_seg7_scan_capture;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0011000;
    localparam logic [6:0] PE = 7'b0000110;
    localparam logic [6:0] PF = 7'b0001110;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .SEG         (seg),
        .DIG_EN      (dig_en),
        .CLR         (clr),
        .VALUE       (value),
        .DIGIT_VALID (digit_valid),
        .UPDATE      (update),
        .ERR         (err)
    );

    always @(negedge clk) if (update === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] e, input int n);
        seg = s;
        dig_en = e;
        step(n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr = 1'b0; seg = PB; dig_en = 4'b0000;
        step(3);
        rst_n = 1'b1;
        step(1);
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value: got %h want 0000", value); end
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update: got %b want 0", update); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single;
        int u0;
        u0 = upd_cnt;
        hold(P2, 4'b0001, 4);
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL single_early: got %b want 0000", digit_valid); end
        dig_en = 4'b0000;
        step(1);
        total++; if (value !== 16'h0002) begin bad++; $display("FAIL single_value: got %h want 0002", value); end
        total++; if (digit_valid !== 4'b0001) begin bad++; $display("FAIL single_valid: got %b want 0001", digit_valid); end
        total++; if (update !== 1'b1) begin bad++; $display("FAIL single_update: got %b want 1", update); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
        step(1);
        total++; if (update !== 1'b0) begin bad++; $display("FAIL single_update_width: got %b want 0", update); end
        total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", upd_cnt - u0); end
    endtask

    task automatic test_scan;
        logic [6:0] pats [4];
        int u0;
        pats[0] = P1; pats[1] = P0; pats[2] = PF; pats[3] = P9;
        u0 = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            hold(pats[i], 4'(1 << i), 6);
            hold(PB, 4'b0000, 1);
        end
        total++; if (value !== 16'h9F01) begin bad++; $display("FAIL scan_value: got %h want 9f01", value); end
        total++; if (digit_valid !== 4'hF) begin bad++; $display("FAIL scan_valid: got %b want 1111", digit_valid); end
        total++; if (upd_cnt - u0 !== 4) begin bad++; $display("FAIL scan_pulses: got %0d want 4", upd_cnt - u0); end
        u0 = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            hold(pats[i], 4'(1 << i), 6);
            hold(PB, 4'b0000, 1);
        end
        total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL rescan_pulses: got %0d want 0", upd_cnt - u0); end
        total++; if (value !== 16'h9F01) begin bad++; $display("FAIL rescan_value: got %h want 9f01", value); end
    endtask

    task automatic test_glitch;
        int u0;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL clr_valid: got %b want 0000", digit_valid); end
        u0 = upd_cnt;
        for (int k = 0; k < 5; k++) begin
            hold(P8, 4'b0010, 2);
            hold(P0, 4'b0010, 2);
        end
        hold(PB, 4'b0000, 2);
        total++; if (digit_valid[1] !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %b want 0", digit_valid[1]); end
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL glitch_value: got %h want 0000", value); end
        total++; if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", upd_cnt - u0); end
    endtask

    task automatic test_err;
        hold(P7, 4'b0100, 4);
        hold(P7, 4'b0000, 1);
        total++; if (value !== 16'h0700) begin bad++; $display("FAIL err_pre_value: got %h want 0700", value); end
        hold(PX, 4'b0100, 4);
        hold(PX, 4'b0000, 1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_illegal: got %b want 1", err); end
        total++; if (value !== 16'h0700) begin bad++; $display("FAIL err_value_kept: got %h want 0700", value); end
        total++; if (digit_valid !== 4'b0100) begin bad++; $display("FAIL err_valid_kept: got %b want 0100", digit_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL err_no_update: got %b want 0", update); end
        hold(P7, 4'b0011, 3);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_multihot: got %b want 1", err); end
        dig_en = 4'b0000;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %b want 0", err); end
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL err_clr_value: got %h want 0000", value); end
        step(1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_after_clr: got %b want 0", err); end
    endtask

    task automatic test_blank;
        hold(P5, 4'b0001, 4);
        hold(P5, 4'b0000, 1);
        total++; if (value !== 16'h0005) begin bad++; $display("FAIL blank_pre_value: got %h want 0005", value); end
        hold(PB, 4'b0001, 4);
        hold(PB, 4'b0000, 1);
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL blank_valid: got %b want 0000", digit_valid); end
        total++; if (update !== 1'b1) begin bad++; $display("FAIL blank_update: got %b want 1", update); end
        total++; if (value !== 16'h0005) begin bad++; $display("FAIL blank_value_kept: got %h want 0005", value); end
        hold(P3, 4'b0001, 4);
        dig_en = 4'b0000;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL clrcommit_value: got %h want 0000", value); end
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL clrcommit_valid: got %b want 0000", digit_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL clrcommit_update: got %b want 0", update); end
        step(2);
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL clrcommit_late: got %b want 0000", digit_valid); end
    endtask

    task automatic test_reset_mid;
        hold(PE, 4'b1000, 4);
        hold(PE, 4'b0000, 1);
        total++; if (value !== 16'hE000) begin bad++; $display("FAIL rmid_pre_value: got %h want e000", value); end
        hold(P4, 4'b0010, 4);
        rst_n = 1'b0;
        step(1);
        total++; if (value !== 16'h0000) begin bad++; $display("FAIL rmid_value: got %h want 0000", value); end
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL rmid_valid: got %b want 0000", digit_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL rmid_update: got %b want 0", update); end
        rst_n = 1'b1;
        step(4);
        total++; if (digit_valid !== 4'b0000) begin bad++; $display("FAIL rmid_early: got %b want 0000", digit_valid); end
        step(1);
        total++; if (value !== 16'h0040) begin bad++; $display("FAIL rmid_commit_value: got %h want 0040", value); end
        total++; if (digit_valid !== 4'b0010) begin bad++; $display("FAIL rmid_commit_valid: got %b want 0010", digit_valid); end
        total++; if (update !== 1'b1) begin bad++; $display("FAIL rmid_commit_update: got %b want 1", update); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_scan;
        test_glitch;
        test_err;
        test_blank;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
